// File: rtl/int_mul_iterative_pkg.sv
// Shared types for the iterative shift-add multiplier.
// Holds the FSM state encoding and the iteration-counter width helper.
// Imported by the datapath and the top level.
package int_mul_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..W-1 with headroom for the increment past the last step.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/int_mul_iterative_if.sv
// Operand/product handshake bundle for int_mul_iterative.
// in_val/in_rdy/in_a/in_b: operand pair; out_val/out_rdy/out_prod: 2W-bit product.
// slave modport is the multiplier side, master is the producer/consumer side.
interface int_mul_iterative_if #(
  parameter int W = 16
);
  logic           in_val;
  logic           in_rdy;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_val;
  logic           out_rdy;
  logic [2*W-1:0] out_prod;

  modport master (
    output in_val, in_a, in_b, out_rdy,
    input  in_rdy, out_val, out_prod
  );

  modport slave (
    input  in_val, in_a, in_b, out_rdy,
    output in_rdy, out_val, out_prod
  );
endinterface

// File: rtl/int_mul_iterative_dpath.sv
// Shift-add multiplier datapath: operand/acc/shift regs, accumulate adder, sign fix-up.
// Latency: one iteration per step cycle; product register written on the last step.
// Backpressure: none; sequenced entirely by load/step/add_en from the control FSM.
// Ports: load (latch operands), step (one iteration), add_en (add multiplicand this step)
//        in; b_lsb, cnt_done, prod out.
module int_mul_iterative_dpath
  import int_mul_iterative_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           add_en,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           b_lsb,
  output logic           cnt_done,
  output logic [2*W-1:0] prod
);
  localparam int CW = cnt_width(W);

  logic [W-1:0]   a_reg, b_reg, acc_hi, acc_lo;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic [W-1:0]   a_abs, b_abs;
  logic           neg_in;
  logic [W-1:0]   sum;
  logic           cout;
  logic [2*W-1:0] full, full_neg;
  logic           neg_cout_unused;

  // Magnitudes: -(-2^(W-1)) wraps to 2^(W-1), which is the right unsigned magnitude.
  always_comb begin
    a_abs  = in_a;
    b_abs  = in_b;
    neg_in = 1'b0;
    if (SIGNED != 0) begin
      a_abs  = in_a[W-1] ? -in_a : in_a;
      b_abs  = in_b[W-1] ? -in_b : in_b;
      neg_in = in_a[W-1] ^ in_b[W-1];
    end
  end

  vc_adder #(.W(W)) u_acc_add (
    .a    (acc_hi),
    .b    (add_en ? a_reg : {W{1'b0}}),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Accumulator after this step's right shift, i.e. the finished product on the last step.
  assign full = {cout, sum, acc_lo[W-1:1]};

  // Two's-complement negate as ~x + 1; zero stays zero since the carry falls off.
  vc_adder #(.W(2*W)) u_neg_add (
    .a    (~full),
    .b    ({(2*W){1'b0}}),
    .cin  (1'b1),
    .sum  (full_neg),
    .cout (neg_cout_unused)
  );

  assign b_lsb    = b_reg[0];
  assign cnt_done = (cnt == CW'(W-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod   <= '0;
    end else if (load) begin
      a_reg  <= a_abs;
      b_reg  <= b_abs;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= neg_in;
    end else if (step) begin
      acc_hi <= {cout, sum[W-1:1]};
      acc_lo <= {sum[0], acc_lo[W-1:1]};
      b_reg  <= b_reg >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt_done) prod <= neg ? full_neg : full;
    end
  end
endmodule

// File: rtl/vc_adder.sv
// Plain W-bit ripple adder with carry in/out: {cout,sum} = a + b + cin.
// Latency: combinational.
// Backpressure: none (no handshake).
module vc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/int_mul_iterative.sv
// Radix-2 shift-add multiplier, one product in flight, val/rdy on both sides.
// Latency: out_val rises W+1 edges after the accepting edge is counted (1 accept + W steps).
// Backpressure: out_rdy low holds DONE with out_val/out_prod stable; in_rdy only in IDLE.
// Ports: clk, reset (async active-high), io (slave side of int_mul_iterative_if).
module int_mul_iterative
  import int_mul_iterative_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset,
  int_mul_iterative_if.slave io
);
  state_t state_q, state_d;
  logic   load, step, add_en, b_lsb, cnt_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    io.in_rdy  = 1'b0;
    io.out_val = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        io.in_rdy = 1'b1;
        if (io.in_val) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_done) state_d = DONE;
      end
      DONE: begin
        io.out_val = 1'b1;
        if (io.out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign add_en = step & b_lsb;

  int_mul_iterative_dpath #(.W(W), .SIGNED(SIGNED)) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .add_en   (add_en),
    .in_a     (io.in_a),
    .in_b     (io.in_b),
    .b_lsb    (b_lsb),
    .cnt_done (cnt_done),
    .prod     (io.out_prod)
  );
endmodule

// File: tb/tb_int_mul_iterative.sv
module tb_int_mul_iterative;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int_mul_iterative_if #(.W(16)) ifu ();
  int_mul_iterative_if #(.W(16)) ifs ();

  int_mul_iterative #(.W(16), .SIGNED(0)) u_dut_u (.clk(clk), .reset(reset), .io(ifu));
  int_mul_iterative #(.W(16), .SIGNED(1)) u_dut_s (.clk(clk), .reset(reset), .io(ifs));

  int n_total = 0;
  int n_pass  = 0;
  int overlap = 0;
  logic [31:0] q_u[$];
  logic [31:0] q_s[$];

  typedef struct {
    bit          sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic f_in_rdy(input bit s);   return s ? ifs.in_rdy : ifu.in_rdy; endfunction
  function automatic logic f_out_val(input bit s);  return s ? ifs.out_val : ifu.out_val; endfunction
  function automatic logic f_out_rdy(input bit s);  return s ? ifs.out_rdy : ifu.out_rdy; endfunction
  function automatic logic [31:0] f_prod(input bit s); return s ? ifs.out_prod : ifu.out_prod; endfunction

  task automatic drive_in(input bit s, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (s) begin ifs.in_val = v; ifs.in_a = a; ifs.in_b = b; end
    else   begin ifu.in_val = v; ifu.in_a = a; ifu.in_b = b; end
  endtask

  task automatic set_out_rdy(input bit s, input logic r);
    if (s) ifs.out_rdy = r;
    else   ifu.out_rdy = r;
  endtask

  // Reference: exact mathematical product reduced to 32 bits.
  function automatic logic [31:0] ref_mul(input bit s, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb;
    if (s) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else   begin sa = longint'(a);          sb = longint'(b); end
    return 32'(sa * sb);
  endfunction

  function automatic logic [15:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hffff;
      3: return 16'h7fff;
      4: return 16'h0001;
      default: return r[15:0];
    endcase
  endfunction

  // Entered at posedge+1 with the chosen DUT idle or about to be; returns product and edge count.
  task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] prod, output int lat);
    int w;
    w = 0;
    drive_in(s, 1'b1, a, b);
    while (!f_in_rdy(s) && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    lat = 1;
    drive_in(s, 1'b0, 16'hdead, 16'hbeef);
    while (!f_out_val(s) && lat < 100) begin @(posedge clk); #1; lat++; end
    prod = f_prod(s);
  endtask

  task automatic rand_drive(input bit s, input int n);
    logic [15:0] a, b;
    int w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        drive_in(s, 1'b0, 16'($urandom), 16'($urandom));
        @(posedge clk); #1;
      end
      a = pick();
      b = pick();
      drive_in(s, 1'b1, a, b);
      w = 0;
      while (!f_in_rdy(s) && w < 200) begin @(posedge clk); #1; w++; end
      if (!f_in_rdy(s)) begin
        check("rand_accept_timeout", 64'(w), 64'(0));
        break;
      end
      if (s) q_s.push_back(ref_mul(s, a, b));
      else   q_u.push_back(ref_mul(s, a, b));
      @(posedge clk); #1;
    end
    drive_in(s, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rand_mon(input bit s, input int n);
    int got, cyc;
    logic [31:0] e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 80000) begin
      @(posedge clk); #1;
      set_out_rdy(s, $urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      if (f_in_rdy(s) && f_out_val(s)) overlap++;
      if (f_out_val(s) && f_out_rdy(s)) begin
        if (s ? (q_s.size() == 0) : (q_u.size() == 0)) begin
          check(s ? "rand_s_extra" : "rand_u_extra", 64'(got), 64'(n));
        end else begin
          e = s ? q_s.pop_front() : q_u.pop_front();
          check(s ? "rand_s_prod" : "rand_u_prod", 64'(f_prod(s)), 64'(e));
        end
        got++;
      end
    end
    check(s ? "rand_s_count" : "rand_u_count", 64'(got), 64'(n));
  endtask

  initial begin
    vec_t vt[8];
    logic [31:0] p;
    int lat;

    vt[0] = '{0, 16'h00ff, 16'h0101, 32'h0000ffff};
    vt[1] = '{0, 16'hffff, 16'hffff, 32'hfffe0001};
    vt[2] = '{0, 16'h0000, 16'h1234, 32'h00000000};
    vt[3] = '{0, 16'hffff, 16'h0001, 32'h0000ffff};
    vt[4] = '{1, 16'hfffd, 16'h0007, 32'hffffffeb};
    vt[5] = '{1, 16'h8000, 16'h8000, 32'h40000000};
    vt[6] = '{1, 16'hfffb, 16'h0000, 32'h00000000};
    vt[7] = '{1, 16'h7fff, 16'h8000, 32'hc0008000};

    drive_in(0, 1'b0, 16'h0, 16'h0);
    drive_in(1, 1'b0, 16'h0, 16'h0);
    set_out_rdy(0, 1'b0);
    set_out_rdy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_in_rdy", 64'(f_in_rdy(s[0])), 64'(1));
      check("reset_out_val", 64'(f_out_val(s[0])), 64'(0));
      check("reset_out_prod", 64'(f_prod(s[0])), 64'(0));
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, consumer always ready.
    set_out_rdy(0, 1'b1);
    set_out_rdy(1, 1'b1);
    foreach (vt[i]) begin
      run_op(vt[i].sgn, vt[i].a, vt[i].b, p, lat);
      check($sformatf("vec%0d_prod", i), 64'(p), 64'(vt[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(17));
    end
    @(posedge clk); #1;

    // Backpressure: hold DONE for 10 cycles while offering a new operand pair.
    set_out_rdy(0, 1'b0);
    run_op(0, 16'd3, 16'd5, p, lat);
    check("bp_prod", 64'(p), 64'(15));
    check("bp_latency", 64'(lat), 64'(17));
    for (int i = 0; i < 10; i++) begin
      drive_in(0, 1'b1, 16'h1111, 16'h2222);
      @(posedge clk); #1;
      check("bp_out_val", 64'(f_out_val(0)), 64'(1));
      check("bp_out_prod", 64'(f_prod(0)), 64'(15));
      check("bp_in_rdy", 64'(f_in_rdy(0)), 64'(0));
    end
    drive_in(0, 1'b0, 16'h0, 16'h0);
    set_out_rdy(0, 1'b1);
    @(posedge clk); #1;
    check("bp_release_in_rdy", 64'(f_in_rdy(0)), 64'(1));
    check("bp_release_out_val", 64'(f_out_val(0)), 64'(0));
    check("bp_release_prod_held", 64'(f_prod(0)), 64'(15));
    @(posedge clk); #1;
    check("bp_ignored_in_val", 64'(f_in_rdy(0)), 64'(1));

    // Asynchronous reset in the middle of CALC.
    drive_in(1, 1'b1, 16'hff9c, 16'd3);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 16'h0, 16'h0);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_out_val", 64'(f_out_val(1)), 64'(0));
    check("rst_mid_in_rdy", 64'(f_in_rdy(1)), 64'(1));
    check("rst_mid_out_prod", 64'(f_prod(1)), 64'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_op(1, 16'd6, 16'd7, p, lat);
    check("rst_after_prod", 64'(p), 64'(42));
    check("rst_after_latency", 64'(lat), 64'(17));
    @(posedge clk); #1;

    // Random back-to-back traffic on both variants at once.
    fork
      rand_drive(0, 1000);
      rand_drive(1, 1000);
      rand_mon(0, 1000);
      rand_mon(1, 1000);
    join
    set_out_rdy(0, 1'b1);
    set_out_rdy(1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rand_u_quiet", 64'(f_out_val(0)), 64'(0));
    check("rand_s_quiet", 64'(f_out_val(1)), 64'(0));
    check("rand_u_left", 64'(q_u.size()), 64'(0));
    check("rand_s_left", 64'(q_s.size()), 64'(0));
    check("rand_overlap", 64'(overlap), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
